// File: rtl/mask_gen_pkg.sv
// Shared types, row geometry and the LFSR step used by the VGA mask generator.
package mask_gen_pkg;

  typedef enum logic [1:0] {
    SLIDE_RIGHT = 2'b00,
    SLIDE_LEFT  = 2'b01,
    RANDOM      = 2'b10,
    REPEAT      = 2'b11
  } mask_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HOLD = 2'b11
  } fsm_e;

  localparam int ROW_W  = 640;
  localparam int SEED_W = 32;
  localparam int LFSR_W = 32;
  localparam int WORDS  = ROW_W / LFSR_W;
  localparam int TILE_W = 8;

  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/mask_generation_vga_lfsr_row_gen.sv
// Combinational unroll of one LFSR step per 32-bit word of a mask row.
module lfsr_row_gen
  import mask_gen_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  output logic [0:ROW_W-1]  row,
  output logic [LFSR_W-1:0] last
);

  // Each word is the next LFSR state, MSB placed at the word's lowest pixel index.
  always_comb begin
    logic [LFSR_W-1:0] s_s;
    s_s = state;
    row = {ROW_W{1'b0}};
    for (int j = 0; j < WORDS; j++) begin
      s_s = lfsr_next(s_s);
      row[j*LFSR_W +: LFSR_W] = s_s;
    end
    last = s_s;
  end

endmodule

// File: rtl/mask_generation_vga.sv
// Row-wide binary mask generator: sliding, LFSR-random and tiled modes behind a
// serial seed load, one row per enabled clock while running.
module mask_generation_vga
  import mask_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [1:0]          mask_type,
  input  logic                pattern,
  input  logic [4:0]          pattern_w,
  input  logic [TILE_W-1:0]   repeatedPattern,
  input  logic                load_pattern,
  output logic [0:ROW_W-1]    mg_mask,
  output logic                rp_valid
);

  fsm_e              state_r, state_nxt;
  mask_type_e        mode_r, mode_nxt;
  logic [0:SEED_W-1] seed_r, seed_nxt;
  logic [LFSR_W-1:0] lfsr_r, lfsr_nxt;
  logic [0:ROW_W-1]  mask_nxt;
  logic              valid_nxt;

  logic [0:ROW_W-1]  rand_row_s;
  logic [LFSR_W-1:0] rand_last_s;
  logic [0:ROW_W-1]  tile_cand_s [TILE_W];
  logic [2:0]        tile_sel_s;

  lfsr_row_gen u_lfsr_row_gen (
    .state (lfsr_r),
    .row   (rand_row_s),
    .last  (rand_last_s)
  );

  // One fixed-period tiling per candidate period 1..8; bit 7 of the tile comes first.
  for (genvar p = 0; p < TILE_W; p++) begin : g_period
    for (genvar i = 0; i < ROW_W; i++) begin : g_pixel
      localparam int IDX = TILE_W - 1 - (i % (p + 1));
      assign tile_cand_s[p][i] = repeatedPattern[IDX];
    end
  end

  // Out-of-range periods fall back to the full 8-bit tile.
  always_comb begin
    if ((pattern_w == 5'd0) || (pattern_w > 5'd8)) begin
      tile_sel_s = 3'd7;
    end else begin
      tile_sel_s = 3'(pattern_w - 5'd1);
    end
  end

  // Next-state and next-output logic; everything holds unless clk_en is high.
  always_comb begin
    state_nxt = state_r;
    mode_nxt  = mode_r;
    seed_nxt  = seed_r;
    lfsr_nxt  = lfsr_r;
    mask_nxt  = mg_mask;
    valid_nxt = 1'b0;
    if (clk_en) begin
      if (load_pattern) begin
        state_nxt = LOAD;
        mode_nxt  = mask_type_e'(mask_type);
        seed_nxt  = {pattern, seed_r[0:SEED_W-2]};
      end else begin
        case (state_r)
          LOAD: begin
            if (mode_r == REPEAT) begin
              mask_nxt  = tile_cand_s[tile_sel_s];
              valid_nxt = 1'b1;
              state_nxt = HOLD;
            end else begin
              mask_nxt  = {seed_r, {(ROW_W-SEED_W){1'b0}}};
              lfsr_nxt  = (seed_r == {SEED_W{1'b0}}) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed_r;
              state_nxt = RUN;
            end
          end
          RUN: begin
            valid_nxt = 1'b1;
            case (mode_r)
              SLIDE_RIGHT: mask_nxt = {mg_mask[ROW_W-1], mg_mask[0:ROW_W-2]};
              SLIDE_LEFT:  mask_nxt = {mg_mask[1:ROW_W-1], mg_mask[0]};
              RANDOM: begin
                mask_nxt = rand_row_s;
                lfsr_nxt = rand_last_s;
              end
              default:     mask_nxt = mg_mask;
            endcase
          end
          IDLE:    state_nxt = IDLE;
          HOLD:    state_nxt = HOLD;
          default: state_nxt = IDLE;
        endcase
      end
    end else begin
      valid_nxt = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      mode_r   <= SLIDE_RIGHT;
      seed_r   <= {SEED_W{1'b0}};
      lfsr_r   <= {LFSR_W{1'b0}};
      mg_mask  <= {ROW_W{1'b0}};
      rp_valid <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      mode_r   <= mode_nxt;
      seed_r   <= seed_nxt;
      lfsr_r   <= lfsr_nxt;
      mg_mask  <= mask_nxt;
      rp_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_mask_generation_vga.sv
// Directed self-checking bench for mask_generation_vga.
module tb_mask_generation_vga;

  localparam int ROW_W = 640;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_en;
  logic [1:0]       mask_type;
  logic             pattern;
  logic [4:0]       pattern_w;
  logic [7:0]       repeatedPattern;
  logic             load_pattern;
  logic [0:ROW_W-1] mg_mask;
  logic             rp_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mask_generation_vga dut (
    .clk             (clk),
    .rst             (rst),
    .clk_en          (clk_en),
    .mask_type       (mask_type),
    .pattern         (pattern),
    .pattern_w       (pattern_w),
    .repeatedPattern (repeatedPattern),
    .load_pattern    (load_pattern),
    .mg_mask         (mg_mask),
    .rp_valid        (rp_valid)
  );

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift a 32-bit seed in LSB first so the loaded seed reads back as v.
  task automatic load_seed(input logic [1:0] mt, input logic [31:0] v);
    for (int b = 0; b < 32; b++) begin
      mask_type    = mt;
      load_pattern = 1'b1;
      pattern      = v[b];
      tick();
    end
    load_pattern = 1'b0;
  endtask

  // Bit-level reference LFSR: one step per word, word MSB at lowest pixel.
  task automatic model_rand(inout logic [31:0] st, output logic [0:ROW_W-1] row);
    logic fb;
    for (int j = 0; j < ROW_W / 32; j++) begin
      fb = st[31] ^ st[21] ^ st[1] ^ st[0];
      st = {st[30:0], fb};
      for (int k = 0; k < 32; k++) row[32*j + k] = st[31-k];
    end
  endtask

  logic [0:ROW_W-1] model;
  logic [0:ROW_W-1] init_img;
  logic [0:ROW_W-1] exp_row;
  logic [0:ROW_W-1] zero_row;
  logic [31:0]      st;
  logic [7:0]       tile8;
  logic [4:0]       pw_list [2];

  initial begin
    rst = 1'b1; clk_en = 1'b1; mask_type = 2'b00; pattern = 1'b0;
    pattern_w = 5'd0; repeatedPattern = 8'h00; load_pattern = 1'b0;
    zero_row = '0;
    tick(); tick();
    check("reset_mask", mg_mask, zero_row);
    check("reset_valid", {639'd0, rp_valid}, 640'd0);
    rst = 1'b0;

    // Slide right; a mask_type change after the load must be ignored.
    load_seed(2'b00, 32'h03D0A052);
    mask_type = 2'b01;
    tick();
    init_img = {32'h03D0A052, 608'h0};
    check("sr_load_valid", {639'd0, rp_valid}, 640'd0);
    check("sr_init_image", mg_mask, init_img);
    model = init_img;
    for (int r = 1; r <= 641; r++) begin
      tick();
      model = {model[ROW_W-1], model[0:ROW_W-2]};
      check($sformatf("sr_valid_%0d", r), {639'd0, rp_valid}, 640'd1);
      check($sformatf("sr_row_%0d", r), mg_mask, model);
      if (r == 640) check("sr_row640_init", mg_mask, init_img);
    end

    // Slide left with corner bits.
    load_seed(2'b01, 32'h80000001);
    tick();
    tick();
    exp_row = '0;
    exp_row[30]  = 1'b1;
    exp_row[639] = 1'b1;
    check("sl_row1", mg_mask, exp_row);
    check("sl_valid1", {639'd0, rp_valid}, 640'd1);
    for (int r = 2; r <= 640; r++) tick();
    init_img = {32'h80000001, 608'h0};
    check("sl_row640_init", mg_mask, init_img);

    // Random with zero seed, including a 5-cycle clk_en gap.
    load_seed(2'b10, 32'h0);
    tick();
    check("rnd_load_valid", {639'd0, rp_valid}, 640'd0);
    st = 32'h1;
    for (int r = 1; r <= 481; r++) begin
      if (r == 201) begin
        clk_en = 1'b0;
        for (int h = 0; h < 5; h++) begin
          tick();
          check($sformatf("rnd_hold_valid_%0d", h), {639'd0, rp_valid}, 640'd0);
          check($sformatf("rnd_hold_mask_%0d", h), mg_mask, model);
        end
        clk_en = 1'b1;
      end
      tick();
      model_rand(st, model);
      check($sformatf("rnd_row_%0d", r), mg_mask, model);
      check($sformatf("rnd_valid_%0d", r), {639'd0, rp_valid}, 640'd1);
      check($sformatf("rnd_nonzero_%0d", r), {639'd0, (mg_mask == zero_row)}, 640'd0);
    end

    // Reset in the middle of RUN.
    rst = 1'b1;
    tick();
    check("rst_run_mask", mg_mask, zero_row);
    check("rst_run_valid", {639'd0, rp_valid}, 640'd0);
    rst = 1'b0;
    tick();
    check("rst_idle_valid", {639'd0, rp_valid}, 640'd0);

    // Repeat, period 3: "101" tiled.
    repeatedPattern = 8'b10101111;
    pattern_w = 5'd3;
    mask_type = 2'b11;
    load_pattern = 1'b1;
    tick();
    load_pattern = 1'b0;
    tick();
    for (int i = 0; i < ROW_W; i++) exp_row[i] = ((i % 3) != 1);
    check("rep3_valid", {639'd0, rp_valid}, 640'd1);
    check("rep3_mask", mg_mask, exp_row);
    tick();
    check("rep3_hold_valid", {639'd0, rp_valid}, 640'd0);
    check("rep3_hold_mask", mg_mask, exp_row);

    // Repeat with out-of-range periods: full 8-bit tile.
    tile8 = 8'b10101111;
    for (int i = 0; i < ROW_W; i++) exp_row[i] = tile8[7 - (i % 8)];
    pw_list[0] = 5'd0;
    pw_list[1] = 5'd20;
    for (int n = 0; n < 2; n++) begin
      pattern_w = pw_list[n];
      load_pattern = 1'b1;
      tick();
      load_pattern = 1'b0;
      tick();
      check($sformatf("rep8_valid_pw%0d", pw_list[n]), {639'd0, rp_valid}, 640'd1);
      check($sformatf("rep8_mask_pw%0d", pw_list[n]), mg_mask, exp_row);
      tick();
      check($sformatf("rep8_hold_pw%0d", pw_list[n]), {639'd0, rp_valid}, 640'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
